// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer. Each output channel has a single
// holding slot, so one stalled consumer does not block the other channels.
module stream_demux #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = 2,
    parameter int CNTW  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SELW-1:0]      in_sel,
    input  logic                 in_bcast,
    output logic [N-1:0]         out_valid,
    input  logic [N-1:0]         out_ready,
    output logic [N*WIDTH-1:0]   out_data,
    output logic [CNTW-1:0]      drop_cnt,
    output logic                 drop_pulse
);

    logic [N-1:0]     r_valid;
    logic [WIDTH-1:0] r_data [N];
    logic [CNTW-1:0]  r_drop_cnt;
    logic             r_drop_pulse;

    logic [N-1:0]     w_free;
    logic             w_free_all;
    logic             w_free_sel;
    logic             w_sel_ok;
    logic             w_accept;
    logic             w_drop;
    logic [N-1:0]     w_load;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + CNTW'(1);
    endfunction

    // A slot being drained this cycle counts as free, so a channel can
    // take a new word every cycle without a bubble.
    always_comb begin
        w_free     = '0;
        w_free_all = 1'b1;
        w_free_sel = 1'b1;
        for (int k = 0; k < N; k++) begin
            w_free[k]  = !r_valid[k] || out_ready[k];
            w_free_all = w_free_all & w_free[k];
            if (int'(in_sel) == k) begin
                w_free_sel = w_free[k];
            end
        end
    end

    assign w_sel_ok = (int'(in_sel) < N);
    assign in_ready = in_bcast ? w_free_all : w_free_sel;
    assign w_accept = in_valid && in_ready;
    assign w_drop   = w_accept && !in_bcast && !w_sel_ok;

    always_comb begin
        w_load = '0;
        for (int k = 0; k < N; k++) begin
            w_load[k] = w_accept && (in_bcast || (w_sel_ok && int'(in_sel) == k));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= '0;
            r_drop_cnt   <= '0;
            r_drop_pulse <= 1'b0;
            for (int k = 0; k < N; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            r_drop_pulse <= w_drop;
            if (w_drop) begin
                r_drop_cnt <= sat_inc(r_drop_cnt);
            end
            for (int k = 0; k < N; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= 1'b1;
                    r_data[k]  <= in_data;
                end else if (out_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int k = 0; k < N; k++) begin
            out_data[k*WIDTH +: WIDTH] = r_data[k];
        end
    end

    assign out_valid  = r_valid;
    assign drop_cnt   = r_drop_cnt;
    assign drop_pulse = r_drop_pulse;

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshakes on every port.
- Steers each input word to one selected output channel, or to all channels in broadcast mode.
- Each channel has a one-entry holding register, so a stalled channel does not block words addressed to other channels.
- Routes transaction words from the ATM front-end to per-function consumers, for example display, account and dispense.

Parameters:
- WIDTH, 8, data word width in bits.
- N, 4, number of output channels; legal range 2..16.
- SELW, 2, select width; must satisfy 2**SELW >= N.
- CNTW, 8, width of the dropped-word counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the input word this cycle.
- in_data  input  WIDTH  input word.
- in_sel  input  SELW  destination channel index.
- in_bcast  input  1  1 = deliver to all N channels; in_sel is ignored.
- out_valid  output  N  bit k = channel k holds a word.
- out_ready  input  N  bit k = consumer k takes the word this cycle.
- out_data  output  N*WIDTH  channel k data is bits [k*WIDTH +: WIDTH].
- drop_cnt  output  CNTW  count of dropped words (out-of-range select).
- drop_pulse  output  1  one-cycle pulse per dropped word.

Behaviour:
- Single clock domain; all state changes on the rising edge of clk.
- Reset (rst=1 at an edge):
  - All out_valid = 0, all out_data = 0.
  - drop_cnt = 0, drop_pulse = 0.
  - rst overrides any handshake in the same cycle; words held mid-operation are discarded.
- Per-channel slot state is EMPTY or FULL; out_valid[k] is the slot's FULL flag.
- Channel k drains when out_valid[k] && out_ready[k]. The slot returns to EMPTY at the next edge unless it is refilled in the same cycle.
- free[k] = !out_valid[k] || out_ready[k]. A slot being drained counts as free, giving full throughput with no bubble.
- in_ready is combinational, with no dependency on in_valid:
  - Unicast, in_sel < N: in_ready = free[in_sel].
  - Unicast, in_sel >= N: in_ready = 1.
  - Broadcast: in_ready = AND of free[k] over all k (all-or-nothing).
- Acceptance occurs when in_valid && in_ready:
  - Unicast, valid select: slot in_sel loads in_data and becomes FULL at the next edge.
  - Broadcast: every slot loads in_data.
  - Unicast, in_sel >= N: the word is consumed and discarded. drop_pulse = 1 on the following cycle. drop_cnt increments and saturates at 2**CNTW-1.
- Latency: a word accepted at edge t is visible on out_valid/out_data from edge t onward, i.e. one cycle after it is presented.
- out_data[k] is stable while out_valid[k]=1 and out_ready[k]=0.
- Simultaneous drain and load on the same channel: the new word replaces the old one with no gap, and out_valid stays 1.
- Broadcast with any channel stalled (FULL and not ready): in_ready = 0, and no channel loads, including free ones.
- in_sel and in_bcast are sampled only at acceptance; changes while in_ready = 0 are legal.
- Channels drain independently; the block does not reorder words within a channel.

Test Plan:
- Reset then idle:
  - rst=1 for 2 cycles, then release.
  - Required: out_valid=0, out_data=0, drop_cnt=0, in_ready=1.
- Unicast routing:
  - Send 0xA5 to sel=2 with all out_ready=1.
  - Required: next cycle out_valid=4'b0100 and channel 2 data = 0xA5. Channel 2 then empties the following cycle.
- Backpressure isolation:
  - Hold out_ready[1]=0 and send 0x11 to sel=1.
  - Then send 0x22 to sel=1: required in_ready=0, and channel 1 keeps 0x11.
  - Send 0x33 to sel=3: required accepted, channel 3 = 0x33.
  - Raise out_ready[1]: required 0x22 is accepted on that same cycle.
- Broadcast:
  - Send 0x5A with in_bcast=1 while channel 0 is stalled full.
  - Required: in_ready=0, and no slot changes.
  - Release channel 0: required all out_valid=4'b1111, each channel data = 0x5A.
- Back-to-back throughput:
  - Keep out_ready[0]=1 and stream 10 words to sel=0.
  - Required: one word delivered per cycle, in order, with no bubbles.
- Out-of-range select and reset mid-operation:
  - Run with N=3, SELW=2; send 300 words with sel=3.
  - Required: one drop_pulse per word, and drop_cnt saturates at 255.
  - Assert rst while channels are full: required all outputs return to reset values on the next cycle.
